switch_pio_debounce: RTL
========================

Name: switch_pio_debounce

Overview:
- Parametrised Avalon-MM slave input PIO for board slide switches and push-buttons; successor to the fixed 8-bit, data-only switch port.
- Adds the following per bit:
  - two-flop synchroniser
  - counter-based debounce
  - edge-capture register with write-1-to-clear
  - interrupt mask and a level interrupt to the Nios II IRQ line.
- Sits between the top-level switch/button pins and the system interconnect.

Parameters:
- WIDTH, 8, number of input bits (1..32).
- DEBOUNCE_CYCLES, 500000, clock cycles an input must hold a new value before it is accepted; minimum 1 (10 ms at 50 MHz).

Ports:
- clk  input  1  system clock.
- reset  input  1  reset.
- address  input  2  Avalon word address.
- chipselect  input  1  slave select.
- write_n  input  1  active-low write strobe.
- writedata  input  32  write data.
- readdata  output  32  registered read data.
- in_port  input  WIDTH  raw asynchronous switch/button pins.
- irq  output  1  interrupt request, active high.

Behaviour:
- Clocking and reset:
  - one clock; reset is synchronous and active-high.
  - On reset, all state clears to 0: sync flops, debounce counters, stable, edgecapture, irqmask, readdata. irq = 0.
- Synchroniser: sync1 <= in_port; sync2 <= sync1. Two cycles of latency. No combinational path from in_port.
- Debounce, per bit i:
  - If sync2[i] == stable[i]: cnt[i] <= 0.
  - Else if cnt[i] == DEBOUNCE_CYCLES-1: stable[i] <= sync2[i] and cnt[i] <= 0.
  - Else: cnt[i] <= cnt[i]+1.
  - Counter width is clog2(DEBOUNCE_CYCLES), minimum 1.
  - A glitch shorter than DEBOUNCE_CYCLES consecutive mismatch cycles is never accepted; any return to match restarts the count.
- Total latency from a clean in_port step to the stable change is 2 + DEBOUNCE_CYCLES clocks.
- After reset, an input held high is accepted as a 0->1 transition once debounced.
- Edge capture:
  - rise[i] = stable[i] 0->1 in the current update.
  - edgecapture[i] is set on the same clock edge that stable[i] rises.
  - Bits stay set until cleared by software.
- Register map, write when chipselect=1 and write_n=0:
  - 0 DATA: read = stable, zero-extended to 32 bits; writes ignored.
  - 1 reserved: reads 0; writes ignored.
  - 2 IRQMASK: read/write, bits [WIDTH-1:0]; upper bits read 0.
  - 3 EDGECAPTURE:
    - read = edgecapture.
    - A write clears each bit whose writedata bit is 1.
    - If an edge and a clear hit the same bit in the same cycle, set wins.
- Read path:
  - readdata <= mux(address) every clock, independent of chipselect; one-cycle read latency.
  - Bits [31:WIDTH] are always 0.
- irq = |(edgecapture & irqmask). It is a level signal combinational from registers only, and it deasserts the cycle after the clearing write lands.
- Reset mid-debounce discards the pending count; no edge is captured for it.

Optional Feature:
- Macro: SWITCH_PIO_ANYEDGE_EN.
- Defined: edgecapture[i] is also set on a stable[i] 1->0 transition, so both edges are captured.
- Undefined: only rising edges are captured; falling transitions update DATA but never set edgecapture.
- The register map and irq equation are identical in both builds.

Test Plan:
- WIDTH=8, DEBOUNCE_CYCLES=4, reset held 2 cycles with in_port=0x00 -> readdata=0, irq=0, reads of all four addresses return 0.
- Drive in_port=0x05 and hold -> DATA reads 0x05 with stable changing exactly 6 cycles after the step; EDGECAPTURE=0x05; irq stays 0 while IRQMASK=0.
- Write IRQMASK=0x04 -> irq=1 the next cycle. Write EDGECAPTURE=0x04 -> edgecapture=0x01 and irq=0 the following cycle.
- Pulse in_port[7] high for 3 cycles (< DEBOUNCE_CYCLES), then low -> DATA bit 7 stays 0 and edgecapture bit 7 stays 0.
- Time the clearing write of EDGECAPTURE bit 1 to the same cycle stable[1] rises -> bit 1 reads 1 (set wins).
- Drop in_port 0x05->0x00 -> DATA=0x00. EDGECAPTURE is unchanged without the macro; it sets bits 0 and 2 with SWITCH_PIO_ANYEDGE_EN defined.

Source files
------------

// File: rtl/switch_pio_debounce.sv
// switch_pio_debounce: Avalon-MM input PIO for slide switches and push-buttons.
// Each input bit passes through a two-flop synchroniser and a counter-based
// debounce filter. Accepted rising edges (both edges when the build macro
// SWITCH_PIO_ANYEDGE_EN is defined) are latched in a write-1-to-clear
// edge-capture register. A masked OR of that register drives a level IRQ.
// Register map: 0 DATA (ro), 1 reserved, 2 IRQMASK (rw), 3 EDGECAPTURE (w1c).
module switch_pio_debounce #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] sync2_q;
  logic [WIDTH-1:0] stable_q;
  logic [WIDTH-1:0] stable_d;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];
  logic [WIDTH-1:0] edgecap_q;
  logic [WIDTH-1:0] edgecap_d;
  logic [WIDTH-1:0] irqmask_q;
  logic [WIDTH-1:0] irqmask_d;
  logic [31:0]      readdata_q;
  logic [31:0]      readdata_d;

  logic             wr_s;
  logic [WIDTH-1:0] edge_s;
  logic [WIDTH-1:0] clr_s;
  logic             unused_wd_s;

  // Upper write-data bits beyond WIDTH carry no meaning for this block.
  assign unused_wd_s = ^writedata;

  // Debounce: a bit is accepted only after DEBOUNCE_CYCLES consecutive mismatches.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync2_q[i] == stable_q[i]) begin
        cnt_d[i] = {CNT_W{1'b0}};
      end else if (cnt_q[i] == CNT_MAX) begin
        stable_d[i] = sync2_q[i];
        cnt_d[i]    = {CNT_W{1'b0}};
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // Register file next-state: edge capture (set beats clear), mask, read mux.
  always_comb begin
    wr_s = chipselect & ~write_n;
`ifdef SWITCH_PIO_ANYEDGE_EN
    edge_s = stable_d ^ stable_q;
`else
    edge_s = stable_d & ~stable_q;
`endif
    if (wr_s && (address == 2'd3)) begin
      clr_s = writedata[WIDTH-1:0];
    end else begin
      clr_s = {WIDTH{1'b0}};
    end
    edgecap_d = (edgecap_q & ~clr_s) | edge_s;
    if (wr_s && (address == 2'd2)) begin
      irqmask_d = writedata[WIDTH-1:0];
    end else begin
      irqmask_d = irqmask_q;
    end
    readdata_d = 32'h0000_0000;
    case (address)
      2'd0:    readdata_d[WIDTH-1:0] = stable_q;
      2'd2:    readdata_d[WIDTH-1:0] = irqmask_q;
      2'd3:    readdata_d[WIDTH-1:0] = edgecap_q;
      default: readdata_d = 32'h0000_0000;
    endcase
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q    <= {WIDTH{1'b0}};
      sync2_q    <= {WIDTH{1'b0}};
      stable_q   <= {WIDTH{1'b0}};
      edgecap_q  <= {WIDTH{1'b0}};
      irqmask_q  <= {WIDTH{1'b0}};
      readdata_q <= 32'h0000_0000;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= {CNT_W{1'b0}};
      end
    end else begin
      sync1_q    <= in_port;
      sync2_q    <= sync1_q;
      stable_q   <= stable_d;
      edgecap_q  <= edgecap_d;
      irqmask_q  <= irqmask_d;
      readdata_q <= readdata_d;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign readdata = readdata_q;
  assign irq      = |(edgecap_q & irqmask_q);

endmodule
